// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: function codes, register-zero index
// and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int REG_ZERO  = 0;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, register 0 hard-wired to zero, synchronous active-low clear.
module regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n)
        mem[i] <= '0;
      else if (we && wa == AW'(i) && i != REG_ZERO)
        mem[i] <= wd;
    end
  end

  // Entry 0 is never written, but mask the read anyway so it is zero by construction.
  assign rd1 = (ra1 == AW'(REG_ZERO)) ? '0 : mem[ra1];
  assign rd2 = (ra2 == AW'(REG_ZERO)) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage in front of the ALU: register read with writeback
// write-through, immediate select, and a one-entry valid/ready output register.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [15:0]      imm,
  input  logic             alusrc,
  input  logic [2:0]       f_in,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       f
);

  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] rb_next;
  logic [WIDTH-1:0] b_next;
  logic             wr_live;
  logic             capture;

  regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we3),
    .wa    (wa3),
    .wd    (wd3),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // A same-cycle writeback bypasses the array so the capture sees the new value.
  assign wr_live = we3 && (wa3 != AW'(REG_ZERO));
  assign a_next  = (wr_live && wa3 == ra1) ? wd3 : rd1;
  assign rb_next = (wr_live && wa3 == ra2) ? wd3 : rd2;
  assign b_next  = alusrc ? {{(WIDTH-16){imm[15]}}, imm} : rb_next;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      f         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      a         <= a_next;
      b         <= b_next;
      f         <= f_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios followed by random
// traffic, checked against an array-based register model and an expected queue.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ra1, ra2, wa3;
  logic [15:0] imm;
  logic        alusrc;
  logic [2:0]  f_in;
  logic        we3;
  logic [31:0] wd3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic [2:0]  f;

  alu_operand_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ra1       (ra1),
    .ra2       (ra2),
    .imm       (imm),
    .alusrc    (alusrc),
    .f_in      (f_in),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .f         (f)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  logic [31:0] regs [32];
  logic [66:0] exp_q [$];   // {a, b, f} of each accepted operation, oldest first

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (we3 && wa3 == idx) return wd3;
    return regs[idx];
  endfunction

  task automatic idle();
    in_valid = 0; ra1 = 0; ra2 = 0; imm = 0; alusrc = 0; f_in = 0;
    we3 = 0; wa3 = 0; wd3 = 0; flush = 0; out_ready = 1; rst_n = 1;
  endtask

  // Apply the currently driven inputs across one rising edge and advance the model.
  task automatic step();
    logic        cap;
    logic [31:0] ea, eb;
    cap = rst_n && in_valid && !flush && (exp_q.size() == 0 || out_ready);
    ea  = model_read(ra1);
    eb  = alusrc ? {{16{imm[15]}}, imm} : model_read(ra2);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      exp_q.delete();
    end else begin
      if (we3 && wa3 != 0) regs[wa3] = wd3;
      if (cap) exp_q.push_back({ea, eb, f_in});
    end
    started = 1;
    #1;
  endtask

  // Monitor: compares the presented operation and the handshake every cycle,
  // then retires the front entry if it leaves at the coming edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'h0, in_ready},
          {31'h0, (!flush && (exp_q.size() == 0 || out_ready))});
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) begin
        chk("a", a, exp_q[0][66:35]);
        chk("b", b, exp_q[0][34:3]);
        chk("f", {29'h0, f}, {29'h0, exp_q[0][2:0]});
        $display("txn a=%h b=%h f=%0d ready=%0d flush=%0d", a, b, f, out_ready, flush);
      end
      if (exp_q.size() != 0 && (!rst_n || flush || out_ready))
        void'(exp_q.pop_front());
    end
  end

  initial begin
    idle();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;

    // Reset with a pending writeback that must be ignored
    rst_n = 0; we3 = 1; wa3 = 3; wd3 = 32'hFFFF_FFFF;
    step(); step();
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_a", a, 32'h0);
    idle(); in_valid = 1; ra1 = 3;
    step();
    chk("reset_r3_a", a, 32'h0);

    // Basic flow
    idle(); we3 = 1; wa3 = 5; wd3 = 32'h7; step();
    idle(); we3 = 1; wa3 = 6; wd3 = 32'h3; step();
    idle(); in_valid = 1; ra1 = 5; ra2 = 6; f_in = F_SUB; step();
    chk("basic_a", a, 32'h7);
    chk("basic_b", b, 32'h3);
    chk("basic_f", {29'h0, f}, 32'h6);
    chk("basic_valid", {31'h0, out_valid}, 32'h1);

    // Immediate and register 0
    idle(); we3 = 1; wa3 = 0; wd3 = 32'h1234; step();
    idle(); in_valid = 1; ra1 = 0; alusrc = 1; imm = 16'h8001; f_in = F_ADD; step();
    chk("imm_a", a, 32'h0);
    chk("imm_b", b, 32'hFFFF_8001);

    // Write-through at the capture edge
    idle(); in_valid = 1; ra1 = 9; ra2 = 9; we3 = 1; wa3 = 9; wd3 = 32'hDEAD_BEEF; step();
    chk("wt_a", a, 32'hDEAD_BEEF);
    chk("wt_b", b, 32'hDEAD_BEEF);

    // Stall, then flush
    idle(); in_valid = 1; ra1 = 5; ra2 = 6; f_in = F_OR; step();
    for (int i = 0; i < 3; i++) begin
      idle(); out_ready = 0; in_valid = 1; ra1 = 6; we3 = 1; wa3 = 5; wd3 = 32'h55; step();
      chk("stall_a", a, 32'h7);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    end
    idle(); flush = 1; in_valid = 1; ra1 = 5; out_ready = 0; step();
    chk("flush_valid", {31'h0, out_valid}, 32'h0);

    // Throughput: four back-to-back captures
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1; ra1 = 5'(i + 5); ra2 = 5'(i); f_in = F_AND; step();
      chk("tput_valid", {31'h0, out_valid}, 32'h1);
    end

    // Random traffic with a narrow index range to provoke collisions
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ra1       = 5'($urandom_range(0, 7));
      ra2       = 5'($urandom_range(0, 7));
      imm       = 16'($urandom);
      alusrc    = 1'($urandom);
      f_in      = 3'($urandom);
      we3       = 1'($urandom);
      wa3       = 5'($urandom_range(0, 7));
      wd3       = $urandom;
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 49) != 0);
      step();
    end

    idle(); in_valid = 0; step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline stage directly upstream of the `alu`: holds the architectural register file, reads two source registers, selects register or sign-extended immediate for operand B, and presents registered `a`, `b`, `f` to the ALU under a valid/ready handshake. It also accepts one writeback per cycle, with same-cycle write-through to the operand reads.

## Interface
- `WIDTH`, 32: data width of registers, `a`, `b`, `wd3`.
- `NREG`, 32: number of registers. Register index width is `$clog2(NREG)` (5 at default).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: upstream presents an instruction.
- `in_ready`  out  1: stage accepts this cycle (combinational).
- `ra1`, `ra2`  in  5: source register indices for A and B.
- `imm`  in  16: immediate, sign-extended to `WIDTH`.
- `alusrc`  in  1: 0 selects B from `ra2`; 1 selects B from `imm`.
- `f_in`  in  3: ALU function code, passed through unchanged.
- `we3`  in  1: writeback enable.
- `wa3`  in  5: writeback index.
- `wd3`  in  WIDTH: writeback data.
- `flush`  in  1: discard held and incoming operation.
- `out_valid`  out  1: `a`/`b`/`f` are valid for the ALU.
- `out_ready`  in  1: ALU side consumes this cycle.
- `a`, `b`  out  WIDTH: registered operands.
- `f`  out  3: registered function code.

## Operation
- **Register file.**
  - Reads are asynchronous.
  - Register 0 always reads 0; writes to index 0 are ignored.
  - A write happens at the edge when `we3 && rst_n`. It is independent of the handshake, `flush` and stall.
- **Write-through.** If `we3 && wa3 == ra1 && wa3 != 0`, operand A takes `wd3` rather than the stored value. The same rule applies to `ra2` for B when `alusrc = 0`.
- **B select.** `alusrc = 1` gives `b = {{(WIDTH-16){imm[15]}}, imm}`.
- **Ready.** `in_ready = !flush && (!out_valid || out_ready)`.
- **Capture** (`in_valid && in_ready`): load `a`, `b` and `f <= f_in`; set `out_valid <= 1`.
- **Drain** (`out_valid && out_ready`, no capture): `out_valid <= 0`; `a`/`b`/`f` hold their last values.
- **Stall** (`out_valid && !out_ready`): `a`/`b`/`f` held bit-stable. Later writes to the captured source registers do not alter the held operands.
- **Flush.** `out_valid <= 0` at the next edge and no capture occurs. `flush` has priority over both capture and drain.
- **Reset** (`rst_n = 0` at an edge): all registers are set to 0, `out_valid = 0`, `a = b = 0`, `f = 0`, and the writeback is ignored. Reset asserted mid-stall discards the held operation.
- No arithmetic is performed here. Widths pass through unchanged; no truncation.

## Timing
- Latency 1 cycle: an operation captured at edge k has `out_valid`/`a`/`b`/`f` visible after edge k.
- Throughput: 1 operation per cycle while `out_ready = 1`. A back-to-back capture and drain in the same cycle replaces the held operation without a bubble.
- **Read-after-write.**
  - Write at edge k plus capture at the same edge, same index: the new value is captured (via write-through).
  - Write at edge k, capture at edge k+1: read from the array.
- Implicit two-state controller: EMPTY (`out_valid = 0`) and FULL (`out_valid = 1`).
  - EMPTY→FULL on capture.
  - FULL→EMPTY on drain-without-capture or `flush`.
  - FULL→FULL on stall or capture+drain.
  - Reset → EMPTY.
- `in_ready` has a combinational path from `out_ready` and `flush` only.

## Structure
- Shared package `alu_pkg`:
  - F codes `F_AND=3'b000`, `F_OR=3'b001`, `F_ADD=3'b010`, `F_SUB=3'b110`, `F_SLT=3'b111`.
  - `REG_ZERO = 0`.
  - Default `WIDTH`.
- Sub-module `regfile`: `NREG × WIDTH` array with 2 asynchronous read ports, 1 synchronous write port, register-0 masking and synchronous active-low clear.
- Write-through muxes, B select, the pipeline register and the handshake live in `alu_operand_stage`.

## Test plan
- **Reset.** Hold `rst_n = 0` for 2 cycles with `we3 = 1`, `wa3 = 3`, `wd3 = 32'hFFFF_FFFF`. Then release and capture `ra1 = 3`. Required: `out_valid = 0` during reset; after release, `a = 0`.
- **Basic flow.**
  - Write r5 = 32'h0000_0007 and r6 = 32'h0000_0003.
  - Then capture `ra1 = 5`, `ra2 = 6`, `alusrc = 0`, `f_in = F_SUB`.
  - Required, one cycle later: `a = 7`, `b = 3`, `f = 3'b110`, `out_valid = 1`.
- **Immediate and register 0.** Capture `ra1 = 0`, `alusrc = 1`, `imm = 16'h8001`, after writing r0 = 32'h1234. Required: `a = 0`, `b = 32'hFFFF_8001`.
- **Write-through.** At the same edge, write r9 = 32'hDEAD_BEEF and capture `ra1 = 9`. Required: `a = 32'hDEAD_BEEF`.
- **Stall and flush.**
  - Capture `a = 7`, then hold `out_ready = 0` for 3 cycles while writing r5 = 32'h55.
  - Required during the stall: `a` stays 7 and `in_ready = 0`.
  - Then assert `flush` with `in_valid = 1`. Required: `out_valid = 0` next cycle and nothing captured.
- **Throughput.** Run 4 back-to-back captures with `out_ready = 1` throughout. Required: 4 consecutive `out_valid = 1` cycles, each with the matching operands.
